// File: rtl/axis_sync_fifo.sv
// axis_sync_fifo: single-clock AXI4-Stream FIFO (TDATA/TUSER/TLAST).
// Ports: axis_aclk/axis_areset, s_axis_* sink, m_axis_* source;
// AXIS_SYNC_FIFO_STATUS_EN adds fifo_level and almost_full.
// Handshake flags are registered from the next count, so no input
// reaches any output handshake combinationally.
module axis_sync_fifo #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int AXIS_TUSER_WIDTH = 4,
  parameter int FIFO_DEPTH       = 16
`ifdef AXIS_SYNC_FIFO_STATUS_EN
  ,
  parameter int AFULL_LEVEL      = FIFO_DEPTH - 2
`endif
) (
  input  logic                        axis_aclk,
  input  logic                        axis_areset,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [AXIS_TUSER_WIDTH-1:0] s_axis_tuser,
  input  logic                        s_axis_tlast,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic [AXIS_TUSER_WIDTH-1:0] m_axis_tuser,
  output logic                        m_axis_tlast,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready
`ifdef AXIS_SYNC_FIFO_STATUS_EN
  ,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
  output logic                            almost_full
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int DW = AXIS_TDATA_WIDTH + AXIS_TUSER_WIDTH + 1;

  logic [DW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic          wr_en;
  logic          rd_en;

  assign wr_en = s_axis_tvalid & s_axis_tready;
  assign rd_en = m_axis_tvalid & m_axis_tready;

  always_comb begin
    count_nxt = count;
    unique case ({wr_en, rd_en})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // Storage has no reset; contents are don't-care while empty.
  always_ff @(posedge axis_aclk) begin
    if (wr_en) begin
      mem[wr_ptr] <= {s_axis_tuser, s_axis_tlast, s_axis_tdata};
    end
  end

  always_ff @(posedge axis_aclk or posedge axis_areset) begin
    if (axis_areset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      s_axis_tready <= 1'b0;
      m_axis_tvalid <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
      count         <= count_nxt;
      s_axis_tready <= (count_nxt != CW'(FIFO_DEPTH));
      m_axis_tvalid <= (count_nxt != '0);
    end
  end

  // First-word fall-through: head entry drives the outputs.
  assign {m_axis_tuser, m_axis_tlast, m_axis_tdata} = mem[rd_ptr];

`ifdef AXIS_SYNC_FIFO_STATUS_EN
  assign fifo_level = count;

  always_ff @(posedge axis_aclk or posedge axis_areset) begin
    if (axis_areset) begin
      almost_full <= 1'b0;
    end else begin
      almost_full <= (count_nxt >= CW'(AFULL_LEVEL));
    end
  end
`endif

endmodule
